mem_access_stage: RTL

//  MEM pipeline stage: consumes the EX/MEM register outputs, runs a handshaked

---
 rtl/mips_pkg.sv | 20 ++
 rtl/mem_wb_reg.sv | 35 +++
 rtl/mem_access_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM pipeline stage.
// Control-field bit positions and the data returned on a bus timeout.
package mips_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_GNT = 2'd1,
      WAIT_RD  = 2'd2
   } mem_state_t;

   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register. A bubble zeroes the WB control and holds the rest;
// kill_wb loads the data fields but squashes the WB control.
module mem_wb_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        bubble,
   input  logic        kill_wb,
   input  logic        rd_en,
   input  logic [31:0] rd_data,
   input  logic [31:0] alu_result,
   input  logic [4:0]  write_reg,
   input  logic [1:0]  wb,
   output logic [31:0] W_readData,
   output logic [31:0] W_ALUresult,
   output logic [4:0]  W_writeReg,
   output logic [1:0]  W_WB
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         W_readData  <= '0;
         W_ALUresult <= '0;
         W_writeReg  <= '0;
         W_WB        <= '0;
      end else if (bubble) begin
         W_WB <= '0;
      end else begin
         W_ALUresult <= alu_result;
         W_writeReg  <= write_reg;
         W_WB        <= kill_wb ? 2'b00 : wb;
         if (rd_en) W_readData <= rd_data;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: handshaked data-memory load/store, stall generation and MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned accesses are squashed and flagged on m_misalign.
//
// state    | meaning
// IDLE     | no access outstanding; a new op requests combinationally
// WAIT_GNT | request held stable until the memory grants it
// WAIT_RD  | load granted, waiting for rvalid
module mem_access_stage
   import mips_pkg::*;
#(
   parameter int AW      = 32,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [31:0]   M_ALUresult,
   input  logic [31:0]   M_writeData,
   input  logic [4:0]    M_writeReg,
   input  logic [1:0]    M_WB,
   input  logic [2:0]    M_M,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic          dmem_gnt,
   input  logic          dmem_rvalid,
   input  logic [31:0]   dmem_rdata,
   output logic          m_stall,
   output logic          m_bus_err,
`ifdef MISALIGN_TRAP_EN
   output logic          m_misalign,
`endif
   output logic [31:0]   W_readData,
   output logic [31:0]   W_ALUresult,
   output logic [4:0]    W_writeReg,
   output logic [1:0]    W_WB
);

   localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   mem_state_t    state, state_nxt;
   logic [TW-1:0] tmo_cnt;
   logic          is_load, is_store, mem_op, misalign, issue;
   logic          tmo_hit, done, timed_out, req;
   logic [31:0]   rd_data;
   logic          unused_branch;

   assign unused_branch = M_M[M_BRANCH];

   // A load wins when both MemRead and MemWrite are set.
   assign is_load  = M_M[M_MEMREAD];
   assign is_store = M_M[M_MEMWRITE] & ~M_M[M_MEMREAD];
   assign mem_op   = is_load | is_store;

`ifdef MISALIGN_TRAP_EN
   assign misalign   = (state == IDLE) & mem_op & (M_ALUresult[1:0] != 2'b00);
   assign m_misalign = misalign & rst;
`else
   assign misalign   = 1'b0;
`endif

   assign issue   = mem_op & ~misalign;
   assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == '0);

   always_comb begin
      state_nxt = state;
      req       = 1'b0;
      done      = 1'b0;
      timed_out = 1'b0;
      case (state)
         IDLE: begin
            if (issue) begin
               req = 1'b1;
               if (dmem_gnt) begin
                  if (is_load) state_nxt = WAIT_RD;
                  else         done      = 1'b1;
               end else begin
                  state_nxt = WAIT_GNT;
               end
            end
         end
         WAIT_GNT: begin
            req = 1'b1;
            if (dmem_gnt) begin
               if (is_load) begin
                  state_nxt = WAIT_RD;
               end else begin
                  done      = 1'b1;
                  state_nxt = IDLE;
               end
            end else if (tmo_hit) begin
               done      = 1'b1;
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         WAIT_RD: begin
            if (dmem_rvalid) begin
               done      = 1'b1;
               state_nxt = IDLE;
            end else if (tmo_hit) begin
               done      = 1'b1;
               timed_out = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_data = timed_out ? BUS_ERR_DATA : dmem_rdata;

   // Gated by rst so the request and stall drop the moment reset asserts.
   assign dmem_req   = req & rst;
   assign dmem_we    = dmem_req & is_store;
   assign dmem_addr  = {M_ALUresult[AW-1:2], 2'b00};
   assign dmem_wdata = M_writeData;
   assign m_stall    = issue & ~done & rst;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Down-counter reloaded on every entry into a wait state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmo_cnt <= '0;
      end else if ((state_nxt != IDLE) && (state_nxt != state)) begin
         tmo_cnt <= TMO_LOAD;
      end else if ((state != IDLE) && (tmo_cnt != '0)) begin
         tmo_cnt <= tmo_cnt - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           m_bus_err <= 1'b0;
      else if (timed_out) m_bus_err <= 1'b1;
   end

   mem_wb_reg u_mem_wb_reg (
      .clk        (clk),
      .rst        (rst),
      .bubble     (m_stall),
      .kill_wb    (misalign),
      .rd_en      (is_load & ~misalign),
      .rd_data    (rd_data),
      .alu_result (M_ALUresult),
      .write_reg  (M_writeReg),
      .wb         (M_WB),
      .W_readData (W_readData),
      .W_ALUresult(W_ALUresult),
      .W_writeReg (W_writeReg),
      .W_WB       (W_WB)
   );

endmodule
